lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Panel timing generator that sits directly downstream of the LCD ID reader. After reset it waits for the strapped panel ID to settle, latches it once, and selects a fixed timing set (resolution, sync, porch). It then generates HS/VS/DE, the pixel request and coordinate stream toward the frame source, and drives the RGB bus. The RGB bus output enable stays low until the ID is latched, so the ID straps on the shared RGB pins remain readable.

## Interface
- ID_SETTLE, 4: cycles after reset release before the ID is sampled (≥2; must cover the ID reader's one-cycle capture).
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- lcd_id  in  16  panel ID code from the ID reader; only bits [2:0] are decoded.
- pixel_data  in  24  RGB888 pixel; valid one cycle after the matching data_req.
- data_req  out  1  pixel request to the frame source.
- pixel_xpos  out  11  column of the requested pixel; 0 when data_req is low.
- pixel_ypos  out  11  row of the requested pixel; 0 when data_req is low.
- h_disp  out  11  latched active width; 0 before latch.
- v_disp  out  11  latched active height; 0 before latch.
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0 in RUN.
- lcd_hs  out  1  horizontal sync, active low.
- lcd_vs  out  1  vertical sync, active low.
- lcd_de  out  1  data enable.
- lcd_rgb_o  out  24  RGB output; 0 when lcd_de is low.
- lcd_rgb_oe  out  1  RGB bus output enable.
- lcd_bl  out  1  backlight enable.
- lcd_rst  out  1  panel reset, active low.

## Operation
- FSM states: WAIT, LATCH and RUN.
  - WAIT: a settle counter runs from 0 to ID_SETTLE-1, then the FSM moves to LATCH.
  - LATCH: one cycle. Captures lcd_id[2:0] and loads the timing registers, then moves to RUN.
  - RUN: terminal state. Left only by reset.
- Timing table, listed as code: HSYNC/HBP/HDISP/HFP (HTOTAL); VSYNC/VBP/VDISP/VFP (VTOTAL).
  - 0: 41/2/480/2 (525); 10/2/272/2 (286).
  - 1: 128/88/800/40 (1056); 2/33/480/10 (525).
  - 2: 20/140/1024/160 (1344); 3/20/600/12 (635).
  - 4: 128/88/800/40 (1056); 2/33/480/10 (525).
  - 5: 10/80/1280/70 (1440); 3/10/800/10 (823).
  - 3, 6 and 7 use the code 0 set.
- lcd_id is ignored outside the LATCH cycle. A later ID change has no effect until the next reset.
- Counters (11-bit, RUN only; both held at 0 otherwise):
  - h_cnt counts 0..HTOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and wraps to 0 after VTOTAL-1.
- Let HS0 = HSYNC+HBP and VS0 = VSYNC+VBP.
- lcd_hs = 0 when h_cnt < HSYNC. lcd_vs = 0 when v_cnt < VSYNC. Both are 1 outside RUN.
- v_act is true when VS0 ≤ v_cnt < VS0+VDISP.
- lcd_de = v_act and HS0 ≤ h_cnt < HS0+HDISP.
- data_req = v_act and HS0-1 ≤ h_cnt < HS0+HDISP-1.
- pixel_xpos = h_cnt-(HS0-1) and pixel_ypos = v_cnt-VS0 while data_req is high.
- lcd_rgb_o = lcd_de ? pixel_data : 0.
- lcd_rgb_oe, lcd_bl and lcd_rst are 1 in RUN and 0 otherwise.
- Arithmetic: all comparisons are unsigned 11-bit. HS0 ≥ 1 for every table entry, so HS0-1 never underflows.

## Timing
- Reset values:
  - lcd_hs = 1 and lcd_vs = 1.
  - Every other output is 0.
  - FSM in WAIT; settle counter, h_cnt and v_cnt at 0.
- Sequence after rst_n deasserts, counting cycle 0 as the first rising edge:
  - Cycles 0..ID_SETTLE-1: WAIT.
  - Cycle ID_SETTLE: LATCH.
  - From cycle ID_SETTLE+1: RUN, starting at h_cnt=0, v_cnt=0, with frame_start = 1 in that cycle.
- h_disp and v_disp update at the end of the LATCH cycle.
- data_req leads lcd_de by exactly one cycle. The pixel requested at (x, y) appears on lcd_rgb_o in the following cycle.
- lcd_hs, lcd_vs, lcd_de, data_req and the coordinates are combinational from registered counters.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). A fresh WAIT/LATCH/RUN sequence starts on release.
- Frame period = HTOTAL×VTOTAL cycles. Example: code 0 gives 525×286 = 150150.

## Test plan
- **Code 0, ID_SETTLE=4.**
  - frame_start at cycle 5 after reset release; h_disp=480, v_disp=272.
  - lcd_hs low for 41 cycles of each 525-cycle line; lcd_vs low for 10 lines.
  - frame_start repeats every 150150 cycles.
- **Code 5.**
  - h_disp=1280, v_disp=800; line length 1440.
  - First lcd_de at h_cnt=90, v_cnt=13; 1280 lcd_de cycles per active line; 800 active lines.
- **Code 3.** Same timing as code 0 (480×272, 525×286).
- **lcd_id changes 0→1 in RUN.**
  - h_disp stays 480 and the timing does not change.
  - After a new reset with code 1: h_disp=800.
- **Handshake, with the frame source returning pixel_data = {pixel_ypos[7:0], pixel_xpos[7:0], 8'h5A} one cycle late.**
  - data_req rises exactly one cycle before lcd_de.
  - First data_req has xpos=0, ypos=0; lcd_rgb_o matches the request made one cycle earlier; last xpos = HDISP-1.
- **rst_n pulsed low mid-line in RUN.**
  - Immediately: lcd_rgb_oe, lcd_bl, lcd_rst and lcd_de go to 0, and lcd_hs and lcd_vs go to 1.
  - After release, the restart timing matches the first scenario.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_timing_gen
//
// Panel timing generator that sits after the LCD ID reader. After reset it
// waits ID_SETTLE cycles so the strapped panel ID can settle. It then latches
// lcd_id[2:0] once and selects a fixed timing set. From then on it produces
// HS/VS/DE, the pixel request and coordinate stream toward the frame source,
// and the gated RGB output.
//
// The RGB output enable stays low until the ID is latched. This keeps the ID
// straps on the shared RGB pins readable while the ID is being sampled.
//
// Parameters
//   ID_SETTLE   cycles spent in WAIT before the ID is sampled (>= 2)
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   lcd_id       in   panel ID code, only bits [2:0] are decoded
//   pixel_data   in   RGB888 pixel, valid one cycle after its data_req
//   data_req     out  pixel request to the frame source
//   pixel_xpos   out  column of the requested pixel (0 when data_req low)
//   pixel_ypos   out  row of the requested pixel (0 when data_req low)
//   h_disp       out  latched active width (0 before latch)
//   v_disp       out  latched active height (0 before latch)
//   frame_start  out  one-cycle pulse at h_cnt = 0, v_cnt = 0 in RUN
//   lcd_hs       out  horizontal sync, active low
//   lcd_vs       out  vertical sync, active low
//   lcd_de       out  data enable
//   lcd_rgb_o    out  RGB output, 0 when lcd_de is low
//   lcd_rgb_oe   out  RGB bus output enable
//   lcd_bl       out  backlight enable
//   lcd_rst      out  panel reset, active low
// -----------------------------------------------------------------------------
module lcd_timing_gen #(
  parameter int unsigned ID_SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lcd_id,
  input  logic [23:0] pixel_data,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        frame_start,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb_o,
  output logic        lcd_rgb_oe,
  output logic        lcd_bl,
  output logic        lcd_rst
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LATCH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // The window bounds are precomputed when the ID is latched. The per-cycle
  // logic is then only comparators; no adders sit in the output paths.
  // All "end" bounds are exclusive.
  typedef struct packed {
    logic [10:0] hsync;        // lcd_hs low while h_cnt < hsync
    logic [10:0] h_req_start;  // HS0 - 1
    logic [10:0] h_act_start;  // HS0
    logic [10:0] h_req_end;    // HS0 + HDISP - 1
    logic [10:0] h_act_end;    // HS0 + HDISP
    logic [10:0] h_last;       // HTOTAL - 1
    logic [10:0] vsync;        // lcd_vs low while v_cnt < vsync
    logic [10:0] v_act_start;  // VS0
    logic [10:0] v_act_end;    // VS0 + VDISP
    logic [10:0] v_last;       // VTOTAL - 1
    logic [10:0] hdisp;
    logic [10:0] vdisp;
  } timing_t;

  // Settle counter is sized for the values 0 .. ID_SETTLE-1.
  localparam int unsigned SETTLE_W = (ID_SETTLE > 2) ? $clog2(ID_SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(ID_SETTLE - 1);

  // ---------------------------------------------------------------------------
  // Timing table. Codes 3, 6 and 7 fall back to the code 0 set.
  // ---------------------------------------------------------------------------
  function automatic timing_t timing_lookup(input logic [2:0] code);
    logic [10:0] hs, hbp, hd, hfp;
    logic [10:0] vs, vbp, vd, vfp;
    timing_t     t;
    case (code)
      3'd1, 3'd4: begin
        hs = 11'd128; hbp = 11'd88;  hd = 11'd800;  hfp = 11'd40;
        vs = 11'd2;   vbp = 11'd33;  vd = 11'd480;  vfp = 11'd10;
      end
      3'd2: begin
        hs = 11'd20;  hbp = 11'd140; hd = 11'd1024; hfp = 11'd160;
        vs = 11'd3;   vbp = 11'd20;  vd = 11'd600;  vfp = 11'd12;
      end
      3'd5: begin
        hs = 11'd10;  hbp = 11'd80;  hd = 11'd1280; hfp = 11'd70;
        vs = 11'd3;   vbp = 11'd10;  vd = 11'd800;  vfp = 11'd10;
      end
      default: begin
        hs = 11'd41;  hbp = 11'd2;   hd = 11'd480;  hfp = 11'd2;
        vs = 11'd10;  vbp = 11'd2;   vd = 11'd272;  vfp = 11'd2;
      end
    endcase
    // HS0 >= 1 for every entry, so the "- 1" terms cannot underflow.
    t.hsync       = hs;
    t.h_act_start = hs + hbp;
    t.h_req_start = hs + hbp - 11'd1;
    t.h_act_end   = hs + hbp + hd;
    t.h_req_end   = hs + hbp + hd - 11'd1;
    t.h_last      = hs + hbp + hd + hfp - 11'd1;
    t.vsync       = vs;
    t.v_act_start = vs + vbp;
    t.v_act_end   = vs + vbp + vd;
    t.v_last      = vs + vbp + vd + vfp - 11'd1;
    t.hdisp       = hd;
    t.vdisp       = vd;
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t                state_q;
  state_t                state_d;
  logic [SETTLE_W-1:0]   settle_cnt;
  timing_t               tim_q;
  logic [10:0]           h_cnt;
  logic [10:0]           v_cnt;
  logic                  run;
  logic                  v_act;
  logic                  unused_id_bits;

  // Only the low three ID bits select a timing set.
  assign unused_id_bits = ^lcd_id[15:3];

  // ---------------------------------------------------------------------------
  // FSM: WAIT -> LATCH -> RUN. RUN is left only through reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples pre-edge values, whatever order the blocks happen to run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case. Every path through the
  // block then assigns it, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:  if (settle_cnt == SETTLE_LAST) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_WAIT;
    endcase
  end

  // The settle counter counts 0 .. ID_SETTLE-1 in WAIT and then holds. It
  // has no further use once the FSM leaves WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state_q == ST_WAIT && settle_cnt != SETTLE_LAST) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Timing registers. lcd_id is looked at only in the LATCH cycle, so a later
  // strap change has no effect until the next reset.
  // ---------------------------------------------------------------------------
  // NOTE: the timing set is explicitly reset. h_disp/v_disp must read 0
  // before the latch, and they come straight from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_q <= '0;
    end else if (state_q == ST_LATCH) begin
      tim_q <= timing_lookup(lcd_id[2:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Raster counters. They are held at 0 until RUN, so the first RUN cycle is
  // the frame origin.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state_q == ST_RUN) begin
      if (h_cnt == tim_q.h_last) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == tim_q.v_last) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational decode of the registered counters.
  // Everything is gated by run. Outside RUN the outputs therefore hold their
  // reset values, including during reset itself, because the state register
  // clears asynchronously.
  // ---------------------------------------------------------------------------
  assign run   = (state_q == ST_RUN);
  assign v_act = run && (v_cnt >= tim_q.v_act_start) && (v_cnt < tim_q.v_act_end);

  assign lcd_hs      = !(run && (h_cnt < tim_q.hsync));
  assign lcd_vs      = !(run && (v_cnt < tim_q.vsync));
  assign lcd_de      = v_act && (h_cnt >= tim_q.h_act_start) && (h_cnt < tim_q.h_act_end);

  // The request window is the DE window moved one cycle earlier. The frame
  // source has a one-cycle latency, so its reply lands on the DE cycle.
  assign data_req    = v_act && (h_cnt >= tim_q.h_req_start) && (h_cnt < tim_q.h_req_end);
  assign pixel_xpos  = data_req ? (h_cnt - tim_q.h_req_start) : 11'd0;
  assign pixel_ypos  = data_req ? (v_cnt - tim_q.v_act_start) : 11'd0;

  assign frame_start = run && (h_cnt == 11'd0) && (v_cnt == 11'd0);
  assign lcd_rgb_o   = lcd_de ? pixel_data : 24'd0;

  assign h_disp      = tim_q.hdisp;
  assign v_disp      = tim_q.vdisp;

  assign lcd_rgb_oe  = run;
  assign lcd_bl      = run;
  assign lcd_rst     = run;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing_gen
//
// Self-checking bench for lcd_timing_gen.
//
// The reference model does not track FSM state. It only counts rising edges
// since reset release (m_edges). The ID is captured on edge index ID_SETTLE.
// RUN begins after edge index ID_SETTLE. The raster position is then plain
// division of the RUN cycle index by the line and frame lengths.
//
// The frame source returns {ypos[7:0], xpos[7:0], 8'h5A} one cycle after
// each request. When there was no request, it drives random data instead.
// -----------------------------------------------------------------------------
module tb_lcd_timing_gen;

  localparam int ID_SETTLE = 4;

  // Expected outputs during reset, packed as in dut_vec():
  // {frame_start, hs, vs, de, req, oe, bl, rst, xpos, ypos, h_disp, v_disp, rgb}
  localparam logic [75:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 5'b00000, 44'd0, 24'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lcd_id = 16'd0;
  logic [23:0] pixel_data = 24'd0;
  logic        data_req;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        frame_start, lcd_hs, lcd_vs, lcd_de;
  logic [23:0] lcd_rgb_o;
  logic        lcd_rgb_oe, lcd_bl, lcd_rst;

  lcd_timing_gen #(.ID_SETTLE(ID_SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lcd_id      (lcd_id),
    .pixel_data  (pixel_data),
    .data_req    (data_req),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .h_disp      (h_disp),
    .v_disp      (v_disp),
    .frame_start (frame_start),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb_o   (lcd_rgb_o),
    .lcd_rgb_oe  (lcd_rgb_oe),
    .lcd_bl      (lcd_bl),
    .lcd_rst     (lcd_rst)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing table indexed by the raw 3-bit code; 3, 6, 7 repeat code 0.
  int t_hsync [8] = '{41, 128,   20, 41, 128,   10, 41, 41};
  int t_hbp   [8] = '{ 2,  88,  140,  2,  88,   80,  2,  2};
  int t_hdisp [8] = '{480, 800, 1024, 480, 800, 1280, 480, 480};
  int t_hfp   [8] = '{ 2,  40,  160,  2,  40,   70,  2,  2};
  int t_vsync [8] = '{10,   2,    3, 10,   2,    3, 10, 10};
  int t_vbp   [8] = '{ 2,  33,   20,  2,  33,   10,  2,  2};
  int t_vdisp [8] = '{272, 480,  600, 272, 480,  800, 272, 272};
  int t_vfp   [8] = '{ 2,  10,   12,  2,  10,   10,  2,  2};

  function automatic logic [75:0] dut_vec();
    return {frame_start, lcd_hs, lcd_vs, lcd_de, data_req, lcd_rgb_oe, lcd_bl, lcd_rst,
            pixel_xpos, pixel_ypos, h_disp, v_disp, lcd_rgb_o};
  endfunction

  // Outputs expected after `edges` rising edges since reset release.
  function automatic logic [75:0] model_out(input int edges, input logic [2:0] code,
                                            input logic [23:0] prev_tag,
                                            output logic req, output int x, output int y);
    int r, htot, vtot, h, v, hs0, vs0;
    logic run, vact, de, fs, hs, vs;
    logic [10:0] hd, vd;
    logic [23:0] rgb;
    run = (edges > ID_SETTLE);
    req = 1'b0; x = 0; y = 0; de = 1'b0; fs = 1'b0; hs = 1'b1; vs = 1'b1;
    hd = 11'd0; vd = 11'd0; rgb = 24'd0;
    if (run) begin
      r    = edges - ID_SETTLE - 1;
      htot = t_hsync[code] + t_hbp[code] + t_hdisp[code] + t_hfp[code];
      vtot = t_vsync[code] + t_vbp[code] + t_vdisp[code] + t_vfp[code];
      h    = r % htot;
      v    = (r / htot) % vtot;
      hs0  = t_hsync[code] + t_hbp[code];
      vs0  = t_vsync[code] + t_vbp[code];
      vact = (v >= vs0) && (v < vs0 + t_vdisp[code]);
      de   = vact && (h >= hs0) && (h < hs0 + t_hdisp[code]);
      req  = vact && (h + 1 >= hs0) && (h + 1 < hs0 + t_hdisp[code]);
      if (req) begin
        x = h + 1 - hs0;
        y = v - vs0;
      end
      fs  = (h == 0) && (v == 0);
      hs  = !(h < t_hsync[code]);
      vs  = !(v < t_vsync[code]);
      hd  = 11'(t_hdisp[code]);
      vd  = 11'(t_vdisp[code]);
      rgb = de ? prev_tag : 24'd0;
    end
    return {fs, hs, vs, de, req, run, run, run, 11'(x), 11'(y), hd, vd, rgb};
  endfunction

  // Model state: edges since release, and the code captured on the latch edge.
  int          m_edges = 0;
  logic [2:0]  m_code  = 3'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_code  <= 3'd0;
    end else begin
      if (m_edges == ID_SETTLE) m_code <= lcd_id[2:0];
      m_edges <= m_edges + 1;
    end
  end

  // Frame source plus per-cycle compare.
  logic        src_req = 1'b0;
  logic [10:0] src_x = 11'd0, src_y = 11'd0;
  logic        m_req;
  int          m_x, m_y;
  logic [23:0] m_prev_tag = 24'd0;
  logic [75:0] exp_v;

  always @(negedge clk) begin
    pixel_data = src_req ? {src_y[7:0], src_x[7:0], 8'h5A} : 24'($urandom);
    #1;
    exp_v = model_out(m_edges, m_code, m_prev_tag, m_req, m_x, m_y);
    check("cycle", dut_vec(), exp_v);
    m_prev_tag = m_req ? {8'(m_y), 8'(m_x), 8'h5A} : 24'd0;
    src_req = data_req;
    src_x   = pixel_xpos;
    src_y   = pixel_ypos;
  end

  // Run statistics gathered by run_cycles (cycle index 0 = first RUN cycle).
  int s_hs_low, s_vs_low, s_de, s_req, s_first_de, s_first_req, s_first_x, s_first_y, s_max_x;

  task automatic run_cycles(input int n);
    s_hs_low = 0; s_vs_low = 0; s_de = 0; s_req = 0;
    s_first_de = -1; s_first_req = -1; s_first_x = -1; s_first_y = -1; s_max_x = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #2;
      if (!lcd_hs) s_hs_low++;
      if (!lcd_vs) s_vs_low++;
      if (lcd_de) begin
        s_de++;
        if (s_first_de < 0) s_first_de = i;
      end
      if (data_req) begin
        s_req++;
        if (s_first_req < 0) begin
          s_first_req = i;
          s_first_x   = int'(pixel_xpos);
          s_first_y   = int'(pixel_ypos);
        end
        if (int'(pixel_xpos) > s_max_x) s_max_x = int'(pixel_xpos);
      end
    end
  endtask

  // Assert reset mid-cycle (checking the asynchronous return to reset values),
  // release it, and walk up to the first RUN cycle.
  task automatic start(input logic [15:0] id, input int exp_hd, input int exp_vd);
    @(posedge clk);
    #(1 + $urandom_range(0, 2));
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), RESET_VEC);
    lcd_id = id;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= ID_SETTLE; i++) begin
      @(posedge clk); #1;
      if (i == ID_SETTLE - 1)
        check("latch_cycle", {frame_start, h_disp, lcd_rgb_oe, lcd_hs}, {1'b0, 11'd0, 1'b0, 1'b1});
    end
    check("first_run", {frame_start, lcd_rgb_oe, lcd_bl, lcd_rst}, 4'b1111);
    check("disp_latched", {h_disp, v_disp}, {11'(exp_hd), 11'(exp_vd)});
  endtask

  initial begin
    logic [2:0] code;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), RESET_VEC);

    // Code 0: sync widths and first active line.
    start({13'($urandom), 3'd0}, 480, 272);
    run_cycles(13 * 525);
    check("c0_hs_low",    s_hs_low, 13 * 41);
    check("c0_vs_low",    s_vs_low, 10 * 525);
    check("c0_de_count",  s_de, 480);
    check("c0_req_count", s_req, 480);
    check("c0_first_de",  s_first_de, 12 * 525 + 43);
    check("c0_req_lead",  s_first_req, 12 * 525 + 42);
    check("c0_first_xy",  {s_first_x, s_first_y}, {32'd0, 32'd0});
    check("c0_last_x",    s_max_x, 479);

    // Code 5: large panel, first active line at v=13.
    start({13'($urandom), 3'd5}, 1280, 800);
    run_cycles(14 * 1440);
    check("c5_first_de",  s_first_de, 13 * 1440 + 90);
    check("c5_de_count",  s_de, 1280);
    check("c5_hs_low",    s_hs_low, 14 * 10);
    check("c5_vs_low",    s_vs_low, 3 * 1440);
    check("c5_req_lead",  s_first_req, 13 * 1440 + 89);
    check("c5_last_x",    s_max_x, 1279);

    // Code 3 falls back to the code 0 set.
    start({13'($urandom), 3'd3}, 480, 272);
    run_cycles(2 * 525);
    check("c3_hs_low", s_hs_low, 2 * 41);
    check("c3_vs_low", s_vs_low, 2 * 525);

    // ID changes 0 -> 1 in RUN: no effect until the next reset.
    start({13'($urandom), 3'd0}, 480, 272);
    run_cycles(600);
    lcd_id = {13'($urandom), 3'd1};
    run_cycles(13 * 525 - 600);
    check("idchg_hdisp",    h_disp, 11'd480);
    check("idchg_de_count", s_de, 480);
    check("idchg_first_de", s_first_de, 12 * 525 + 43 - 600);

    start({13'($urandom), 3'd1}, 800, 480);
    run_cycles(1056);
    check("c1_hs_low", s_hs_low, 128);
    check("c1_vs_low", s_vs_low, 1056);

    // Random codes, strap noise in RUN and mid-line resets.
    for (int k = 0; k < 5; k++) begin
      code = 3'($urandom_range(0, 7));
      start({13'($urandom), code}, t_hdisp[code], t_vdisp[code]);
      run_cycles($urandom_range(500, 3000));
      lcd_id = 16'($urandom);
      run_cycles($urandom_range(200, 1500));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
